// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between an instruction-fetch
//            requester (port 0, read-only) and a data load/store requester
//            (port 1). The winning request is registered onto the memory
//            side. Grants rotate round-robin, and every transaction is
//            bounded by a timeout so a dead memory cannot hang the pipeline.
// Revision : 1.0 - initial release
//
// Parameters:
//   bitnum   width of address, write data and read data
//   TIMEOUT  max cycles spent waiting for mem_ready before abort (>= 2)
//   CNTW     timeout counter width, 2**CNTW > TIMEOUT
//
// Optional build macro:
//   ARB_DATA_PRIO_EN  when defined, port 1 always wins a simultaneous
//                     request (port 0 may starve while req1 stays high).
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req0, addr0                port 0 request (held until ack0) and address
//   req1, addr1, wdata1, we1   port 1 request (held until ack1), address,
//                              write data, write enable
//   mem_req, mem_addr,         registered memory request, address,
//   mem_wdata, mem_we          write data, write enable
//   mem_ready, mem_rdata       memory completion and same-cycle read data
//   sel                        current/last grant index for datapath muxes
//   ack0, ack1                 one-cycle completion pulses
//   rdata                      registered read data, valid with ack0/ack1
//   err                        one-cycle pulse alongside ack on timeout
// ============================================================================
module mem_port_arbiter #(
  parameter int bitnum  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [bitnum-1:0] addr0,
  input  logic              req1,
  input  logic [bitnum-1:0] addr1,
  input  logic [bitnum-1:0] wdata1,
  input  logic              we1,
  output logic              mem_req,
  output logic [bitnum-1:0] mem_addr,
  output logic [bitnum-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  input  logic [bitnum-1:0] mem_rdata,
  output logic              sel,
  output logic              ack0,
  output logic              ack1,
  output logic [bitnum-1:0] rdata,
  output logic              err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counter value seen on the edge that must abort the transaction.
  localparam logic [CNTW-1:0] C_CNT_LAST = CNTW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              mem_req_q, mem_req_d;
  logic [bitnum-1:0] mem_addr_q, mem_addr_d;
  logic [bitnum-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [bitnum-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              winner;

  // Grant selection: a lone requester always wins; on contention the port
  // that did not win last time gets the memory (or port 1 with priority).
  always_comb begin
    winner = req1;
    if (req0 && req1) begin
`ifdef ARB_DATA_PRIO_EN
      winner = 1'b1;
`else
      winner = ~last_q;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel_d       = winner;
          mem_addr_d  = winner ? addr1 : addr0;
          mem_wdata_d = winner ? wdata1 : '0;
          mem_we_d    = winner & we1;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        if (mem_ready) begin
          // Completion wins over a timeout landing on the same edge.
          rdata_d   = mem_rdata;
          ack0_d    = ~sel_q;
          ack1_d    = sel_q;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          last_d    = sel_q;
          state_d   = IDLE;
        end else if (cnt_q == C_CNT_LAST) begin
          rdata_d   = '0;
          ack0_d    = ~sel_q;
          ack1_d    = sel_q;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          last_d    = sel_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign sel       = sel_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between two pipeline requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Registers the winning request and drives the memory side.
- Exports `sel` so the existing 2:1 address/data muxes in the datapath are steered from the same grant.
- Round-robin between ports, with a per-transaction timeout so a dead memory cannot hang the pipeline.

Parameters:
- bitnum, 32, width of address, write data and read data.
- TIMEOUT, 16, max cycles spent waiting for mem_ready before abort; must be ≥2.
- CNTW, 5, width of the timeout counter; must satisfy 2^CNTW > TIMEOUT.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 request; held high until ack0.
- addr0  input  bitnum  port 0 address.
- req1  input  1  port 1 request; held high until ack1.
- addr1  input  bitnum  port 1 address.
- wdata1  input  bitnum  port 1 write data.
- we1  input  1  port 1 write enable (port 0 is read-only).
- mem_req  output  1  memory request.
- mem_addr  output  bitnum  registered address.
- mem_wdata  output  bitnum  registered write data.
- mem_we  output  1  registered write enable.
- mem_ready  input  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  input  bitnum  memory read data.
- sel  output  1  current/last grant index, drives the datapath muxes.
- ack0  output  1  one-cycle completion pulse for port 0.
- ack1  output  1  one-cycle completion pulse for port 1.
- rdata  output  bitnum  registered read data, valid while ack0 or ack1 is high.
- err  output  1  one-cycle pulse alongside ack on timeout.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, sel, ack0, ack1, rdata, err.
  - Round-robin pointer `last`=1, so port 0 wins the first contention.
  - Timeout counter cleared.
  - Reset mid-transaction drops mem_req immediately; no ack is issued.
- FSM states: IDLE, BUSY.
- IDLE, on an edge with any req high:
  - Pick the winner. If only one port requests, it wins. If both request, the winner is the port != last.
  - Register sel=winner and latch the winner's addr into mem_addr.
  - Port 1 winner: latch wdata1/we1. Port 0 winner: mem_we=0, mem_wdata=0.
  - Set mem_req=1, clear the counter, go to BUSY. mem_req rises in the cycle after req is sampled (1-cycle latency).
- BUSY:
  - mem_req, mem_addr, mem_wdata, mem_we and sel are held stable.
  - On an edge with mem_ready=1: rdata<=mem_rdata, ack[sel]<=1 for exactly one cycle, mem_req<=0, mem_we<=0, last<=sel, go to IDLE.
  - Otherwise the counter increments.
  - On the edge where counter==TIMEOUT-1 and mem_ready=0: abort. ack[sel]<=1, err<=1, rdata<=0, mem_req<=0, last<=sel, go to IDLE.
  - mem_ready on that same edge takes precedence over timeout: normal completion, err=0.
- Back-to-back: IDLE always lasts ≥1 cycle between transactions, so a port's minimum turnaround is 3 cycles (req→mem_req→ready→ack).
- Requesters drop req in the cycle ack is seen. req still high in the ack cycle would be re-sampled as a new request, so this is mandatory.
- Requests and mem_ready in IDLE are ignored except for grant selection; a stray mem_ready in IDLE has no effect.
- sel holds the last grant value in IDLE; it never changes while in BUSY.
- ack0 and ack1 are never high in the same cycle.

Optional Feature:
- Macro: ARB_DATA_PRIO_EN.
- Defined: when both ports request in IDLE, port 1 (data) always wins and `last` is ignored for selection. This prevents pipeline stalls on memory-stage accesses. Port 0 can starve while req1 stays high.
- Undefined: round-robin as above.

Test Plan:
- Reset then req0=1, addr0=0x100, mem_ready high 2 cycles after mem_req -> mem_req rises 1 cycle after req0, mem_addr=0x100, sel=0, ack0 one-cycle pulse with rdata=mem_rdata (0xDEADBEEF), err=0.
- req0 and req1 held high together for 4 transactions, mem_ready immediate -> grant order 0,1,0,1, sel matches, one idle cycle between transactions; with ARB_DATA_PRIO_EN -> order 1,1,1,1.
- req1=1, we1=1, addr1=0x20, wdata1=0x55AA55AA -> mem_we=1, mem_wdata=0x55AA55AA held through BUSY, ack1 pulse, mem_we returns to 0.
- req1 with mem_ready held 0, TIMEOUT=16 -> after 16 BUSY cycles ack1=1 and err=1 for one cycle, rdata=0, mem_req drops, a following req0 is granted.
- mem_ready asserted exactly on the timeout edge -> normal completion, err=0, rdata=mem_rdata.
- rst_n pulsed low mid-BUSY -> mem_req, sel and the acks go to 0 immediately without waiting for clk; no ack after release; next req0 is granted normally.
